// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the CPU pipeline and the hazard controller: decoded ID-stage
// fields and the MEM branch outcome in, stall/flush/forwarding controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_rd;
    logic             id_RegWrite;
    logic             id_MemRead;
    logic             mem_PCSrc;

    logic             o_stall_if;
    logic             o_stall_id;
    logic             o_bubble_ex;
    logic             o_flush_id;
    logic             o_flush_ex;
    logic             o_flush_mem;
    logic [1:0]       o_fwd_a;
    logic [1:0]       o_fwd_b;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;
    logic [1:0]       o_state;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_RegWrite, id_MemRead, mem_PCSrc,
        input  o_stall_if, o_stall_id, o_bubble_ex, o_flush_id, o_flush_ex,
               o_flush_mem, o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt, o_state
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
               id_RegWrite, id_MemRead, mem_PCSrc,
        output o_stall_if, o_stall_id, o_bubble_ex, o_flush_id, o_flush_ex,
               o_flush_mem, o_fwd_a, o_fwd_b, o_stall_cnt, o_flush_cnt, o_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: shadow scoreboard, load-use interlock,
// branch flush and registered EX forwarding selects (forwarding when HAZARD_FWD_EN is defined).
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam slot_t            SLOT_NONE = '{valid: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    state_t           state_q, state_d;
    logic             armed_q, armed_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic flush_s, check_s, stall_s, advance_s;
    logic a_ex_s, a_mem_s, b_ex_s, b_mem_s;
    logic unused_s;

    function automatic logic src_match(input logic use_bit, input logic [4:0] rs, input slot_t s);
        return use_bit && (rs != 5'd0) && s.valid && s.wr && (s.rd != 5'd0) && (rs == s.rd);
    endfunction

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem, input logic ex_ld);
        if (m_ex && !ex_ld) begin
            return 2'b01;
        end else if (m_mem) begin
            return 2'b10;
        end else begin
            return 2'b00;
        end
    endfunction
`endif

    // Hazard detection; outputs stay quiet under reset and for the first cycle after it.
    always_comb begin
        a_ex_s  = src_match(hz.id_use_rs1, hz.id_rs1, ex_q);
        a_mem_s = src_match(hz.id_use_rs1, hz.id_rs1, mem_q);
        b_ex_s  = src_match(hz.id_use_rs2, hz.id_rs2, ex_q);
        b_mem_s = src_match(hz.id_use_rs2, hz.id_rs2, mem_q);
        flush_s = armed_q && !reset && hz.mem_PCSrc;
        check_s = armed_q && !reset && hz.id_valid && !flush_s && (state_q != ST_FLUSH);
`ifdef HAZARD_FWD_EN
        stall_s = check_s && ex_q.ld && (a_ex_s || b_ex_s);
`else
        stall_s = check_s && (a_ex_s || a_mem_s || b_ex_s || b_mem_s);
`endif
        advance_s = check_s && !stall_s;
    end

    // Next-state: scoreboard shift, forwarding selects, FSM and saturating counters.
    always_comb begin
        ex_d        = SLOT_NONE;
        mem_d       = ex_q;
        wb_d        = mem_q;
        fwd_a_d     = 2'b00;
        fwd_b_d     = 2'b00;
        state_d     = ST_RUN;
        armed_d     = 1'b1;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (advance_s) begin
            ex_d = '{valid: 1'b1, rd: hz.id_rd, wr: hz.id_RegWrite, ld: hz.id_MemRead};
`ifdef HAZARD_FWD_EN
            fwd_a_d = fwd_sel(a_ex_s, a_mem_s, ex_q.ld);
            fwd_b_d = fwd_sel(b_ex_s, b_mem_s, ex_q.ld);
`endif
        end else begin
            ex_d = SLOT_NONE;
        end

        // A taken branch kills the instruction that would move from EX into MEM.
        if (flush_s) begin
            mem_d = SLOT_NONE;
        end else begin
            mem_d = ex_q;
        end

        if (flush_s) begin
            state_d = ST_FLUSH;
        end else if (stall_s) begin
            state_d = ST_STALL;
        end else begin
            state_d = ST_RUN;
        end

        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end

        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= SLOT_NONE;
            mem_q       <= SLOT_NONE;
            wb_q        <= SLOT_NONE;
            state_q     <= ST_RUN;
            armed_q     <= 1'b0;
            fwd_a_q     <= 2'b00;
            fwd_b_q     <= 2'b00;
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            state_q     <= state_d;
            armed_q     <= armed_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The WB slot mirrors the pipeline only; the write-before-read register file needs no check.
    assign unused_s = ^{wb_q, mem_q.ld, ex_q.ld};

    assign hz.o_stall_if  = stall_s;
    assign hz.o_stall_id  = stall_s;
    assign hz.o_bubble_ex = stall_s;
    assign hz.o_flush_id  = flush_s;
    assign hz.o_flush_ex  = flush_s;
    assign hz.o_flush_mem = flush_s;
    assign hz.o_fwd_a     = fwd_a_q;
    assign hz.o_fwd_b     = fwd_b_q;
    assign hz.o_stall_cnt = stall_cnt_q;
    assign hz.o_flush_cnt = flush_cnt_q;
    assign hz.o_state     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed table-driven bench for pipeline_hazard_ctrl; expectations follow HAZARD_FWD_EN.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;
`ifdef HAZARD_FWD_EN
    localparam int LU = 1;
`else
    localparam int LU = 2;
`endif
    localparam logic [5:0] C_ST = 6'b111000;
    localparam logic [5:0] C_FL = 6'b000111;

    typedef struct {
        logic       rst, pc, v;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       rw, mr;
        logic [5:0] ctl;
        logic [3:0] fwd;
        logic [1:0] st;
        logic [3:0] sc, fc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

    pipeline_hazard_ctrl #(.CNT_W(CW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic pc, input logic v,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic rw, input logic mr, input logic [5:0] ctl,
                                input logic [3:0] fwd, input logic [1:0] st,
                                input logic [3:0] sc, input logic [3:0] fc);
        vec_t r;
        r.rst = rst; r.pc = pc; r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2;
        r.rd = rd; r.rw = rw; r.mr = mr; r.ctl = ctl; r.fwd = fwd; r.st = st; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    function automatic logic [5:0] ctl_now();
        return {hz.o_stall_if, hz.o_stall_id, hz.o_bubble_ex, hz.o_flush_id, hz.o_flush_ex, hz.o_flush_mem};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_ins(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                           input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
        hz.id_valid = v; hz.id_rs1 = rs1; hz.id_rs2 = rs2; hz.id_use_rs1 = u1; hz.id_use_rs2 = u2;
        hz.id_rd = rd; hz.id_RegWrite = rw; hz.id_MemRead = mr;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        hz.mem_PCSrc = 1'b0;
        set_ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(1);

        // rst pc v  rs1 rs2 u1 u2  rd rw mr | ctl fwd{a,b} state stall_cnt flush_cnt (after the edge)
        tbl.push_back(mk(1'b1,1'b0,1'b0, 5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0,1'b0, 6'd0,4'b0000,2'd0,4'd0,4'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b0, 5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0,1'b0, 6'd0,4'b0000,2'd0,4'd0,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd2,5'd3,1'b1,1'b1, 5'd1,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd0,4'd0));
`ifdef HAZARD_FWD_EN
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd5,1'b1,1'b1, 5'd4,1'b1,1'b0, 6'd0,4'b0100,2'd0,4'd0,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd0,5'd0,1'b1,1'b0, 5'd5,1'b1,1'b1, 6'd0,4'b0000,2'd0,4'd0,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd5,5'd5,1'b1,1'b1, 5'd6,1'b1,1'b0, C_ST,4'b0000,2'd1,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd5,5'd5,1'b1,1'b1, 5'd6,1'b1,1'b0, 6'd0,4'b1010,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd2,5'd3,1'b1,1'b1, 5'd1,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0, 5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0,1'b0, 6'd0,4'b0000,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd1,1'b1,1'b1, 5'd7,1'b1,1'b0, 6'd0,4'b1010,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd2,5'd0,1'b1,1'b0, 5'd0,1'b1,1'b1, 6'd0,4'b0000,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd0,5'd0,1'b1,1'b1, 5'd8,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd0,5'd0,1'b1,1'b0, 5'd9,1'b1,1'b1, 6'd0,4'b0000,2'd0,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1, 5'd9,5'd9,1'b1,1'b1, 5'd10,1'b1,1'b0, C_FL,4'b0000,2'd2,4'd1,4'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd9,5'd8,1'b1,1'b1, 5'd11,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd1,4'd1));
`else
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd1,1'b1,1'b1, 5'd4,1'b1,1'b0, C_ST,4'b0000,2'd1,4'd1,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd1,1'b1,1'b1, 5'd4,1'b1,1'b0, C_ST,4'b0000,2'd1,4'd2,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd1,1'b1,1'b1, 5'd4,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd2,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd0,5'd0,1'b1,1'b0, 5'd5,1'b1,1'b1, 6'd0,4'b0000,2'd0,4'd2,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd5,5'd5,1'b1,1'b1, 5'd6,1'b1,1'b0, C_ST,4'b0000,2'd1,4'd3,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd5,5'd5,1'b1,1'b1, 5'd6,1'b1,1'b0, C_ST,4'b0000,2'd1,4'd4,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd5,5'd5,1'b1,1'b1, 5'd6,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd4,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd2,5'd3,1'b1,1'b1, 5'd1,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd4,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b0, 5'd0,5'd0,1'b0,1'b0, 5'd0,1'b0,1'b0, 6'd0,4'b0000,2'd0,4'd4,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd1,1'b1,1'b1, 5'd7,1'b1,1'b0, C_ST,4'b0000,2'd1,4'd5,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd1,5'd1,1'b1,1'b1, 5'd7,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd5,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd2,5'd0,1'b1,1'b0, 5'd0,1'b1,1'b1, 6'd0,4'b0000,2'd0,4'd5,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd0,5'd0,1'b1,1'b1, 5'd8,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd5,4'd0));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd0,5'd0,1'b1,1'b0, 5'd9,1'b1,1'b1, 6'd0,4'b0000,2'd0,4'd5,4'd0));
        tbl.push_back(mk(1'b0,1'b1,1'b1, 5'd9,5'd9,1'b1,1'b1, 5'd10,1'b1,1'b0, C_FL,4'b0000,2'd2,4'd5,4'd1));
        tbl.push_back(mk(1'b0,1'b0,1'b1, 5'd9,5'd8,1'b1,1'b1, 5'd11,1'b1,1'b0, 6'd0,4'b0000,2'd0,4'd5,4'd1));
`endif

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            hz.mem_PCSrc = tbl[i].pc;
            set_ins(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd, tbl[i].rw, tbl[i].mr);
            @(negedge clk);
            chk($sformatf("row%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
            cyc(1);
            chk($sformatf("row%0d_fwd", i), 32'({hz.o_fwd_a, hz.o_fwd_b}), 32'(tbl[i].fwd));
            chk($sformatf("row%0d_state", i), 32'(hz.o_state), 32'(tbl[i].st));
            chk($sformatf("row%0d_stall_cnt", i), 32'(hz.o_stall_cnt), 32'(tbl[i].sc));
            chk($sformatf("row%0d_flush_cnt", i), 32'(hz.o_flush_cnt), 32'(tbl[i].fc));
        end

        // Reset asserted while in STALL, with the load-use hazard still presented in ID.
        reset = 1'b0;
        hz.mem_PCSrc = 1'b0;
        set_ins(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
        cyc(1);
        set_ins(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
        @(negedge clk);
        chk("seqA_stall", 32'(hz.o_stall_if), 32'd1);
        cyc(1);
        chk("seqA_in_stall", 32'(hz.o_state), 32'd1);
        reset = 1'b1;
        #1;
        chk("seqA_rst_ctl", 32'(ctl_now()), 32'd0);
        cyc(1);
        chk("seqA_rst_state", 32'(hz.o_state), 32'd0);
        chk("seqA_rst_scnt", 32'(hz.o_stall_cnt), 32'd0);
        chk("seqA_rst_fcnt", 32'(hz.o_flush_cnt), 32'd0);
        chk("seqA_rst_fwd", 32'({hz.o_fwd_a, hz.o_fwd_b}), 32'd0);
        reset = 1'b0;
        hz.mem_PCSrc = 1'b1;
        @(negedge clk);
        chk("seqA_post_ctl", 32'(ctl_now()), 32'd0);
        cyc(1);
        chk("seqA_post_fcnt", 32'(hz.o_flush_cnt), 32'd0);
        hz.mem_PCSrc = 1'b0;

        // Counter saturation: 16 load-use pairs, then a long run of taken branches.
        for (int k = 0; k < 16; k++) begin
            set_ins(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1);
            cyc(1);
            set_ins(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);
            cyc(LU + 1);
        end
        set_ins(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("seqB_stall_sat", 32'(hz.o_stall_cnt), 32'd15);
        chk("seqB_state_run", 32'(hz.o_state), 32'd0);
        hz.mem_PCSrc = 1'b1;
        cyc(17);
        chk("seqB_flush_sat", 32'(hz.o_flush_cnt), 32'd15);
        chk("seqB_state_flush", 32'(hz.o_state), 32'd2);
        chk("seqB_stall_hold", 32'(hz.o_stall_cnt), 32'd15);
        hz.mem_PCSrc = 1'b0;
        cyc(1);
        chk("seqB_state_back", 32'(hz.o_state), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
